seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Time-multiplexed scan controller for a DIGITS-wide common-anode seven-segment display. It shares one external hex-to-seven-segment decoder across all digits: it presents one nibble at a time on `dec_x` and registers the returned active-low pattern `dec_y` onto the shared segment bus. It also sequences the active-low digit enables, with dead time between digits to suppress ghosting. New display values are double-buffered and take effect only at frame boundaries.

## Interface
- `DIGITS`, 4: number of digits, legal range 1..8.
- `BLANK_CYC`, 2: dead-time cycles per digit slot with all anodes off, ≥1.
- `SHOW_CYC`, 50000: lit cycles per digit slot, ≥1.
- `clk`  in  1  — single clock; all logic is on its rising edge.
- `rst_n`  in  1  — synchronous, active-low reset.
- `en`  in  1  — scan enable. Low forces the display dark.
- `load`  in  1  — one-cycle strobe that captures `data` and `blank` into the pending buffer.
- `data`  in  4*DIGITS  — nibble i drives digit i; digit 0 is in `data[3:0]`.
- `blank`  in  DIGITS  — bit i = 1 keeps digit i dark.
- `dec_x`  out  4  — nibble sent to the external decoder.
- `dec_y`  in  7  — active-low segment pattern returned by the decoder. The path is combinational.
- `an`  out  DIGITS  — active-low digit enables; registered.
- `seg`  out  7  — active-low segments; registered.
- `frame_done`  out  1  — one-cycle pulse at each frame wrap.

## Operation
- Buffers:
  - `pending` holds {data, blank} and is written on every cycle with `load`=1.
  - `shadow` is the buffer actually displayed.
  - `shadow` <= `pending` at each frame start. If `load`=1 on that same edge, `shadow` takes the live `data`/`blank` instead (forwarding), and `pending` also takes them.
- FSM states: IDLE, BLANK, SHOW. `cnt` counts cycles spent in the current state; `idx` is the current digit.
- IDLE:
  - `an`=all 1s, `seg`=7'h7F, `idx`=0.
  - `en`=1 → BLANK; this is a frame start.
- BLANK:
  - `an`=all 1s, `seg`=7'h7F.
  - When `cnt`==BLANK_CYC-1 → SHOW. On that edge: `an` <= ~(1<<idx), and `seg` <= `shadow.blank[idx]` ? 7'h7F : `dec_y`.
- SHOW:
  - `an` and `seg` hold their values.
  - When `cnt`==SHOW_CYC-1 → BLANK. On that edge `an` <= all 1s and `seg` <= 7'h7F.
  - If `idx`==DIGITS-1: `idx` <= 0, `frame_done` <= 1 for one cycle, and the edge is a frame start. Otherwise `idx` <= `idx`+1.
- `dec_x` = `shadow.data[4*idx +: 4]`, continuously. It is stable for all of BLANK, so `dec_y` has settled before SHOW entry.
- `en`=0 in any state: the next edge goes to IDLE with the IDLE output values, `cnt`=0, `idx`=0 and `frame_done`=0. `pending` is kept.
- `cnt` resets to 0 on every state change; its width is clog2(max(BLANK_CYC, SHOW_CYC)).

## Timing
- Reset (`rst_n`=0 sampled at an edge):
  - state=IDLE, `an`=all 1s, `seg`=7'h7F, `frame_done`=0.
  - `cnt`=0, `idx`=0, `pending`=0, `shadow`=0 (`blank` bits cleared).
  - Reset mid-scan has the same effect and overrides `en` and `load`.
- Edge E0 samples `en`=1 in IDLE and enters BLANK with `idx`=0.
  - `an[0]` goes low at E0+BLANK_CYC.
  - `an[0]` goes high at E0+BLANK_CYC+SHOW_CYC.
- Slot period is BLANK_CYC+SHOW_CYC; frame period is DIGITS*(BLANK_CYC+SHOW_CYC).
- `frame_done` is high exactly one cycle per frame, starting at the edge that returns `idx` to 0.
- Never more than one `an` bit is low. No cycle ever has an `an` bit low together with a segment change.
- With DIGITS=1 the frame wraps after every SHOW.

## Test plan
All scenarios use DIGITS=4, BLANK_CYC=2, SHOW_CYC=5, with the team's hex decoder connected.

- **Reset.** Hold `rst_n`=0 for 3 cycles with `en`=1 → `an`=4'hF, `seg`=7'h7F, `frame_done`=0 throughout.
- **Basic scan.** `load` with `data`=16'hF A 1 0, `blank`=0; then raise `en` at E0. Required:
  - `an`=4'hE with `seg`=7'h40 during E0+2..E0+6.
  - `an`=4'hD with `seg`=7'h79 during E0+9..E0+13.
  - Then 4'hB with 7'h08, then 4'h7 with 7'h0E.
  - `frame_done` pulses at E0+28.
  - Dark gaps of exactly 2 cycles between digits.
- **Double buffering.** `load` 16'h2222 in the middle of digit 1 → digits 1–3 still show the old values; the new value appears starting at digit 0 of the next frame.
- **Load at wrap.** Assert `load`=16'h5555 on the same edge as the `frame_done` wrap → the next frame shows 7'h12 on every digit.
- **Blank mask.** Load `blank`=4'b0101 → slots 0 and 2 keep `an` low with `seg`=7'h7F; slots 1 and 3 show their decoded digits.
- **Enable drop.** Deassert `en` while `an`=4'hD → next edge `an`=4'hF, `seg`=7'h7F. Reassert → the scan restarts at digit 0 after 2 BLANK cycles.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-multiplexed scan controller for a common-anode
// seven-segment display. A single external hex decoder is shared by all
// digits. Display values are double-buffered and swap only at frame starts.
//
// Handshake note: there is no valid/ready pair on this block. `load` is a
// single-cycle strobe that is always accepted, and `frame_done` is a
// single-cycle pulse that is never held off.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int BLANK_CYC = 2,
  parameter int SHOW_CYC  = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [DIGITS-1:0]   blank,
  output logic [3:0]          dec_x,
  input  logic [6:0]          dec_y,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic                frame_done,
  output logic [1:0]          dbg_state_o
);

  localparam int MAXC = (BLANK_CYC > SHOW_CYC) ? BLANK_CYC : SHOW_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0]     BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0]     SHOW_LAST  = CW'(SHOW_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] AN_OFF     = '1;
  localparam logic [6:0]        SEG_OFF    = 7'h7F;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                fd_q, fd_d;
  logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
  logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic [4*DIGITS-1:0] shad_data_q, shad_data_d;
  logic [DIGITS-1:0]   shad_blank_q, shad_blank_d;
  logic                frame_start;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a dropped enable always parks the FSM in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (en) state_d = ST_BLANK;
      ST_BLANK: if (cnt_q == BLANK_LAST) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_q == SHOW_LAST) state_d = ST_BLANK;
      default:  state_d = ST_IDLE;
    endcase
    if (!en) state_d = ST_IDLE;
  end

  // Output and datapath next values: counters, digit enables, segments, buffers.
  always_comb begin
    cnt_d       = (state_d != state_q || state_d == ST_IDLE) ? '0 : cnt_q + CW'(1);
    idx_d       = idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    fd_d        = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        idx_d = '0;
        if (en) frame_start = 1'b1;
      end
      ST_BLANK: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        // dec_x has been stable for the whole dead time, so dec_y is settled.
        if (cnt_q == BLANK_LAST) begin
          an_d  = ~(DIGITS'(1) << idx_q);
          seg_d = shad_blank_q[idx_q] ? SEG_OFF : dec_y;
        end
      end
      ST_SHOW: begin
        if (cnt_q == SHOW_LAST) begin
          an_d  = AN_OFF;
          seg_d = SEG_OFF;
          if (idx_q == IDX_LAST) begin
            idx_d       = '0;
            fd_d        = 1'b1;
            frame_start = 1'b1;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      default: begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        idx_d = '0;
      end
    endcase
    if (!en) begin
      an_d        = AN_OFF;
      seg_d       = SEG_OFF;
      cnt_d       = '0;
      idx_d       = '0;
      fd_d        = 1'b0;
      frame_start = 1'b0;
    end
    pend_data_d  = load ? data  : pend_data_q;
    pend_blank_d = load ? blank : pend_blank_q;
    // A load coinciding with a frame start is forwarded straight to the shadow.
    shad_data_d  = frame_start ? (load ? data  : pend_data_q)  : shad_data_q;
    shad_blank_d = frame_start ? (load ? blank : pend_blank_q) : shad_blank_q;
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      fd_q         <= 1'b0;
      pend_data_q  <= '0;
      pend_blank_q <= '0;
      shad_data_q  <= '0;
      shad_blank_q <= '0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      fd_q         <= fd_d;
      pend_data_q  <= pend_data_d;
      pend_blank_q <= pend_blank_d;
      shad_data_q  <= shad_data_d;
      shad_blank_q <= shad_blank_d;
    end
  end

  // Nibble for the current digit goes to the shared decoder continuously.
  always_comb begin
    dec_x = shad_data_q[{idx_q, 2'b00} +: 4];
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign frame_done  = fd_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed scenarios plus randomized traffic, checked every
// cycle against a time-based model of the scan (frame time -> slot/phase).
module tb_seg_scan_ctrl;

  localparam int D  = 4;
  localparam int B  = 2;
  localparam int S  = 5;
  localparam int P  = B + S;
  localparam int FR = D * P;

  // Clock / reset signals.
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [15:0] data;
  logic [3:0]  blank;
  logic [3:0]  dec_x;
  logic [6:0]  dec_y;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model state.
  bit          m_run;
  int          m_t;
  bit          m_wrap;
  logic [15:0] m_pd, m_sd;
  logic [3:0]  m_pb, m_sb;
  logic [3:0]  prev_an;
  logic [6:0]  prev_seg;

  function automatic logic [6:0] hex7(input logic [3:0] x);
    case (x)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  assign dec_y = hex7(dec_x);

  seg_scan_ctrl #(.DIGITS(D), .BLANK_CYC(B), .SHOW_CYC(S)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .data(data), .blank(blank),
    .dec_x(dec_x), .dec_y(dec_y), .an(an), .seg(seg), .frame_done(frame_done),
    .dbg_state_o(dbg_state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic shadow_take();
    m_sd = load ? data  : m_pd;
    m_sb = load ? blank : m_pb;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    m_wrap = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0; m_t = 0;
      m_pd = '0; m_pb = '0; m_sd = '0; m_sb = '0;
      return;
    end
    if (!en) begin
      m_run = 1'b0; m_t = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_t = 0;
      shadow_take();
    end else begin
      m_t++;
      if (m_t == FR) begin
        m_t = 0; m_wrap = 1'b1;
        shadow_take();
      end
    end
    if (load) begin
      m_pd = data; m_pb = blank;
    end
  endtask

  // One clock: edge, model update, then compare #1 later.
  task automatic step();
    int slot;
    bit lit;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic [3:0] e_x;
    @(posedge clk);
    model_edge();
    #1;
    slot  = m_run ? m_t / P : 0;
    lit   = m_run && ((m_t % P) >= B);
    e_x   = m_sd[slot*4 +: 4];
    e_an  = lit ? ~(4'b0001 << slot) : 4'hF;
    e_seg = (lit && !m_sb[slot]) ? hex7(e_x) : 7'h7F;
    chk("an", 32'(an), 32'(e_an));
    chk("seg", 32'(seg), 32'(e_seg));
    chk("frame_done", 32'(frame_done), 32'(m_wrap));
    chk("dec_x", 32'(dec_x), 32'(e_x));
    chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
    if (an != 4'hF && prev_an != 4'hF) chk("seg_stable_lit", 32'(seg), 32'(prev_seg));
    prev_an  = an;
    prev_seg = seg;
  endtask

  // Drive the bench until the model reaches frame time tt, bounded.
  task automatic run_until(input int tt);
    for (int i = 0; i < 300; i++) begin
      if (m_run && m_t == tt) return;
      step();
    end
    chk("run_until_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; data = '0; blank = '0;
    prev_an = 4'hF; prev_seg = 7'h7F;
    m_run = 0; m_t = 0; m_wrap = 0; m_pd = 0; m_pb = 0; m_sd = 0; m_sb = 0;

    // Reset held with en=1.
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", 32'(an), 32'hF);
      chk("rst_seg", 32'(seg), 32'h7F);
      chk("rst_fd", 32'(frame_done), 32'd0);
    end
    rst_n = 1'b1; en = 1'b0;
    step();

    // Basic scan.
    load = 1'b1; data = 16'hFA10; blank = 4'h0;
    step();
    load = 1'b0; en = 1'b1;
    step();  // E0
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k >= 2 && k <= 6)   begin chk("bs_an0", 32'(an), 32'hE); chk("bs_seg0", 32'(seg), 32'h40); end
      if (k >= 9 && k <= 13)  begin chk("bs_an1", 32'(an), 32'hD); chk("bs_seg1", 32'(seg), 32'h79); end
      if (k >= 16 && k <= 20) begin chk("bs_an2", 32'(an), 32'hB); chk("bs_seg2", 32'(seg), 32'h08); end
      if (k >= 23 && k <= 27) begin chk("bs_an3", 32'(an), 32'h7); chk("bs_seg3", 32'(seg), 32'h0E); end
      if (k == 7 || k == 8 || k == 14 || k == 15) chk("bs_gap", 32'(an), 32'hF);
      chk("bs_fd", 32'(frame_done), 32'(k == 28));
    end

    // Double buffering: load mid digit 1.
    run_until(P + 3);
    load = 1'b1; data = 16'h2222;
    step();
    load = 1'b0;
    run_until(P + 4);     chk("db_old1", 32'(seg), 32'h79);
    run_until(2 * P + 3); chk("db_old2", 32'(seg), 32'h08);
    run_until(3 * P + 3); chk("db_old3", 32'(seg), 32'h0E);
    run_until(3);         chk("db_new0", 32'(seg), 32'h24);

    // Load on the wrap edge.
    run_until(FR - 1);
    load = 1'b1; data = 16'h5555;
    step();
    load = 1'b0;
    chk("lw_fd", 32'(frame_done), 32'd1);
    for (int d = 0; d < D; d++) begin
      run_until(d * P + 3);
      chk("lw_seg", 32'(seg), 32'h12);
    end

    // Blank mask.
    load = 1'b1; blank = 4'b0101;
    step();
    load = 1'b0;
    run_until(0);
    for (int d = 0; d < D; d++) begin
      run_until(d * P + 3);
      chk("bm_an", 32'(an), 32'(~(4'b0001 << d) & 4'hF));
      chk("bm_seg", 32'(seg), (d % 2 == 0) ? 32'h7F : 32'h12);
    end
    load = 1'b1; blank = 4'b0000;
    step();
    load = 1'b0;

    // Enable drop while digit 1 is lit.
    run_until(P + 3);
    chk("ed_pre", 32'(an), 32'hD);
    en = 1'b0;
    step();
    chk("ed_an", 32'(an), 32'hF);
    chk("ed_seg", 32'(seg), 32'h7F);
    step(); step();
    en = 1'b1;
    step();  // restart edge
    step();
    chk("ed_gap", 32'(an), 32'hF);
    step();
    chk("ed_an0", 32'(an), 32'hE);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 39) != 0);
      load  = ($urandom_range(0, 9) == 0);
      data  = 16'($urandom);
      blank = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
